// File: rtl/vga_write_arbiter.sv
// Two-requester round-robin arbiter issuing single AHB-Lite writes to a dual-lockstep VGA slave.
// Ready pulses in the cycle after the request is sampled; define VGA_ARB_DLS_RETRY_EN to reissue once on a lockstep fault.
module vga_write_arbiter #(
    parameter int DLS_WAIT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic        HSEL,
    output logic        HREADY,
    input  logic        HREADYOUT,
    input  logic        DLS_ERROR,
    input  logic        fault_clr,
    output logic        busy,
    output logic        fault,
    output logic        fault_src,
    output logic        timeout,
    output logic        done
);

`ifdef VGA_ARB_DLS_RETRY_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHECK, RETRY} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHECK} state_t;
`endif

    localparam logic [7:0] DLS_LAST = 8'(DLS_WAIT - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        last_grant_r, last_grant_s;
    logic [31:0] addr_r, addr_s, data_r, data_s;
    logic        ready0_r, ready0_s, ready1_r, ready1_s;
    logic [31:0] haddr_r, haddr_s, hwdata_r, hwdata_s;
    logic [1:0]  htrans_r, htrans_s;
    logic        hwrite_r, hwrite_s, hsel_r, hsel_s;
    logic        busy_r, busy_s, done_r, done_s;
    logic        fault_r, fault_s, fault_src_r, fault_src_s, timeout_r, timeout_s;
    logic        grant1_s, err_set_s, to_set_s;
`ifdef VGA_ARB_DLS_RETRY_EN
    logic        chk_err_r, chk_err_s, retried_r, retried_s;
`endif

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_grant_s = last_grant_r;
        addr_s       = addr_r;
        data_s       = data_r;
        ready0_s     = 1'b0;
        ready1_s     = 1'b0;
        done_s       = 1'b0;
        err_set_s    = 1'b0;
        to_set_s     = 1'b0;
        grant1_s     = req1_valid & (~req0_valid | ~last_grant_r);
`ifdef VGA_ARB_DLS_RETRY_EN
        chk_err_s    = chk_err_r;
        retried_s    = retried_r;
`endif
        case (state_r)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    state_s      = ADDR;
                    last_grant_s = grant1_s;
                    addr_s       = grant1_s ? req1_addr : req0_addr;
                    data_s       = grant1_s ? req1_data : req0_data;
                    ready0_s     = ~grant1_s;
                    ready1_s     = grant1_s;
`ifdef VGA_ARB_DLS_RETRY_EN
                    retried_s    = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                state_s = DATA;
                cnt_s   = 8'd0;
`ifdef VGA_ARB_DLS_RETRY_EN
                chk_err_s = 1'b0;
`endif
            end
            DATA: begin
                if (HREADYOUT) begin
                    state_s = CHECK;
                    cnt_s   = 8'd0;
                end else if (cnt_r == TO_LAST) begin
                    state_s  = IDLE;
                    cnt_s    = 8'd0;
                    to_set_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            CHECK: begin
                err_set_s = DLS_ERROR;
`ifdef VGA_ARB_DLS_RETRY_EN
                chk_err_s = chk_err_r | DLS_ERROR;
`endif
                if (cnt_r == DLS_LAST) begin
                    cnt_s = 8'd0;
`ifdef VGA_ARB_DLS_RETRY_EN
                    if ((chk_err_r | DLS_ERROR) & ~retried_r) begin
                        state_s   = RETRY;
                        retried_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
`else
                    state_s = IDLE;
                    done_s  = 1'b1;
`endif
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
`ifdef VGA_ARB_DLS_RETRY_EN
            RETRY: begin
                state_s = ADDR;
            end
`endif
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase

        // Bus outputs are decoded from the upcoming state so they align with it once registered.
        haddr_s  = (state_s == ADDR) ? addr_s : 32'h0000_0000;
        htrans_s = (state_s == ADDR) ? 2'b10 : 2'b00;
        hwrite_s = (state_s == ADDR);
        hsel_s   = (state_s == ADDR);
        hwdata_s = (state_s == DATA) ? data_s : 32'h0000_0000;
        busy_s   = (state_s != IDLE);

        fault_s     = err_set_s ? 1'b1 : (fault_clr ? 1'b0 : fault_r);
        fault_src_s = err_set_s ? last_grant_r : (fault_clr ? 1'b0 : fault_src_r);
        timeout_s   = to_set_s ? 1'b1 : (fault_clr ? 1'b0 : timeout_r);
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            last_grant_r <= 1'b1;
            addr_r       <= 32'h0000_0000;
            data_r       <= 32'h0000_0000;
            ready0_r     <= 1'b0;
            ready1_r     <= 1'b0;
            haddr_r      <= 32'h0000_0000;
            hwdata_r     <= 32'h0000_0000;
            htrans_r     <= 2'b00;
            hwrite_r     <= 1'b0;
            hsel_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            fault_src_r  <= 1'b0;
            timeout_r    <= 1'b0;
`ifdef VGA_ARB_DLS_RETRY_EN
            chk_err_r    <= 1'b0;
            retried_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_grant_r <= last_grant_s;
            addr_r       <= addr_s;
            data_r       <= data_s;
            ready0_r     <= ready0_s;
            ready1_r     <= ready1_s;
            haddr_r      <= haddr_s;
            hwdata_r     <= hwdata_s;
            htrans_r     <= htrans_s;
            hwrite_r     <= hwrite_s;
            hsel_r       <= hsel_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            fault_r      <= fault_s;
            fault_src_r  <= fault_src_s;
            timeout_r    <= timeout_s;
`ifdef VGA_ARB_DLS_RETRY_EN
            chk_err_r    <= chk_err_s;
            retried_r    <= retried_s;
`endif
        end
    end

    assign req0_ready = ready0_r;
    assign req1_ready = ready1_r;
    assign HADDR      = haddr_r;
    assign HWDATA     = hwdata_r;
    assign HTRANS     = htrans_r;
    assign HWRITE     = hwrite_r;
    assign HSEL       = hsel_r;
    assign HREADY     = HREADYOUT;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign fault_src  = fault_src_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed vector table, hand sequences and random transfers
// checked cycle by cycle against a transfer-level timeline model.
module tb_vga_write_arbiter;
    localparam int W  = 2;
    localparam int TO = 255;
`ifdef VGA_ARB_DLS_RETRY_EN
    localparam int RETRY_LAT = 9;
`else
    localparam int RETRY_LAT = 4;
`endif
    localparam int K_IDLE = 0, K_ADDR = 1, K_DATA = 2, K_CHECK = 3, K_RETRY = 4, K_END = 5;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_addr, req0_data, req1_addr, req1_data;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HSEL, HREADY, HREADYOUT, DLS_ERROR, fault_clr;
    logic        busy, fault, fault_src, timeout, done;

    int n_cmp = 0;
    int n_bad = 0;

    vga_write_arbiter #(.DLS_WAIT(W), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR), .fault_clr(fault_clr),
        .busy(busy), .fault(fault), .fault_src(fault_src), .timeout(timeout), .done(done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [75:0] exp;
        logic        hro, dls, clr, v0, v1;
    } ent_t;

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, d0, a1, d1;
        int          st;
        logic [3:0]  em;
        int          eg, ed;
        logic        ef, es, et;
    } vec_t;

    ent_t        q[$];
    vec_t        tv[7];
    logic        lg_m, flt_m, src_m, to_m, cur_g, rnd_clr;
    logic [31:0] cur_a, cur_d;

    function automatic logic [75:0] pk(logic r0, logic r1, logic [31:0] ha, logic [31:0] hw, logic [1:0] ht,
                                       logic wr, logic sel, logic hr, logic bsy, logic dn,
                                       logic flt, logic src, logic tmo);
        return {r0, r1, ha, hw, ht, wr, sel, hr, bsy, dn, flt, src, tmo};
    endfunction

    function automatic logic [75:0] obs();
        return pk(req0_ready, req1_ready, HADDR, HWDATA, HTRANS, HWRITE, HSEL, HREADY,
                  busy, done, fault, fault_src, timeout);
    endfunction

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic nz();
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic chk_v(input string nm, input int idx, input logic [75:0] act, input logic [75:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h required %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // One timeline cycle: expected outputs use model state before this cycle's edge.
    task automatic push(input int kind, input logic first, input logic hro, input logic dls,
                        input logic tlast, input logic dn, input logic v0, input logic v1);
        ent_t e;
        logic ab;
        e.hro = hro; e.dls = dls; e.v0 = v0; e.v1 = v1;
        e.clr = rnd_clr ? ($urandom_range(0, 5) == 0) : 1'b0;
        ab = (kind == K_ADDR);
        e.exp = pk(ab && first && !cur_g, ab && first && cur_g, ab ? cur_a : 32'h0,
                   (kind == K_DATA) ? cur_d : 32'h0, ab ? 2'b10 : 2'b00, ab, ab, hro,
                   (kind != K_IDLE) && (kind != K_END), dn, flt_m, src_m, to_m);
        if (kind == K_CHECK && dls) begin
            flt_m = 1'b1; src_m = cur_g;
        end else if (e.clr) begin
            flt_m = 1'b0; src_m = 1'b0;
        end
        if (tlast) to_m = 1'b1;
        else if (e.clr) to_m = 1'b0;
        q.push_back(e);
    endtask

    task automatic build(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1, input int st,
                         input logic [3:0] em1, input logic [3:0] em2);
        logic tmo, eb;
`ifdef VGA_ARB_DLS_RETRY_EN
        logic err;
`endif
        q.delete();
        req0_addr = a0; req0_data = d0; req1_addr = a1; req1_data = d1;
        cur_g = (v0 && v1) ? !lg_m : v1;
        lg_m  = cur_g;
        cur_a = cur_g ? a1 : a0;
        cur_d = cur_g ? d1 : d0;
        push(K_IDLE, 1'b0, rb(), rb(), 1'b0, 1'b0, v0, v1);
        for (int pass = 0; pass < 2; pass++) begin
            push(K_ADDR, pass == 0, rb(), rb(), 1'b0, 1'b0, nz(), nz());
            tmo = 1'b0;
            for (int i = 0; i < TO; i++) begin
                if (i < ((pass == 0) ? st : 0)) begin
                    push(K_DATA, 1'b0, 1'b0, rb(), i == TO - 1, 1'b0, nz(), nz());
                    tmo = (i == TO - 1);
                end else begin
                    push(K_DATA, 1'b0, 1'b1, rb(), 1'b0, 1'b0, nz(), nz());
                    break;
                end
            end
            if (tmo) begin
                push(K_END, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
                break;
            end
`ifdef VGA_ARB_DLS_RETRY_EN
            err = 1'b0;
`endif
            for (int k = 0; k < W; k++) begin
                eb = (pass == 0) ? em1[k] : em2[k];
                push(K_CHECK, 1'b0, rb(), eb, 1'b0, 1'b0, nz(), nz());
`ifdef VGA_ARB_DLS_RETRY_EN
                err = err | eb;
`endif
            end
`ifdef VGA_ARB_DLS_RETRY_EN
            if (err && pass == 0) begin
                push(K_RETRY, 1'b0, rb(), rb(), 1'b0, 1'b0, nz(), nz());
                continue;
            end
`endif
            push(K_END, 1'b0, rb(), rb(), 1'b0, 1'b1, 1'b0, 1'b0);
            break;
        end
    endtask

    // Called at posedge+1; drives each timeline cycle and compares at posedge+2.
    task automatic play(output int og, output int odn, output logic ofl, output logic osrc, output logic oto);
        og = -1; odn = -1; ofl = 1'b0; osrc = 1'b0; oto = 1'b0;
        for (int j = 0; j < q.size(); j++) begin
            req0_valid = q[j].v0; req1_valid = q[j].v1;
            HREADYOUT = q[j].hro; DLS_ERROR = q[j].dls; fault_clr = q[j].clr;
            #1;
            chk_v("cycle", j, obs(), q[j].exp);
            if (req0_ready && og < 0) og = 0;
            if (req1_ready && og < 0) og = 1;
            if (done && odn < 0) odn = j - 1;
            if (j == q.size() - 1) begin
                ofl = fault; osrc = fault_src; oto = timeout;
            end
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        int og, odn;
        logic ofl, osrc, oto;

        tv[0] = '{1'b1, 1'b1, 32'h5000_0000, 32'h0000_0041, 32'h5000_0004, 32'h0000_0042, 0, 4'h0, 0, 4, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 32'h5000_0008, 32'h0000_0043, 32'h5000_000C, 32'h0000_0044, 0, 4'h0, 1, 4, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 1'b1, 32'h5000_0010, 32'h0000_0045, 32'h5000_0014, 32'h0000_0046, 0, 4'h0, 0, 4, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 32'h5000_0000, 32'h0000_0041, 32'h0000_0000, 32'h0000_0000, 0, 4'h0, 0, 4, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5000_0020, 32'hDEAD_BEEF, 3, 4'h0, 1, 7, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5000_0030, 32'h1234_5678, 0, 4'h1, 1, RETRY_LAT, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b1, 1'b0, 32'h5000_0040, 32'hCAFE_0001, 32'h0000_0000, 32'h0000_0000, TO, 4'h0, 0, -1, 1'b1, 1'b1, 1'b1};

        HRESETn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; HREADYOUT = 1'b1; DLS_ERROR = 1'b0;
        fault_clr = 1'b0; req0_addr = 32'h0; req0_data = 32'h0; req1_addr = 32'h0; req1_data = 32'h0;
        lg_m = 1'b1; flt_m = 1'b0; src_m = 1'b0; to_m = 1'b0; rnd_clr = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk_v("reset", 0, obs(), pk(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int t = 0; t < 7; t++) begin
            build(tv[t].v0, tv[t].v1, tv[t].a0, tv[t].d0, tv[t].a1, tv[t].d1, tv[t].st, tv[t].em, 4'h0);
            play(og, odn, ofl, osrc, oto);
            chk_i($sformatf("vec%0d_grant", t), og, tv[t].eg);
            chk_i($sformatf("vec%0d_done_lat", t), odn, tv[t].ed);
            chk_i($sformatf("vec%0d_fault", t), ofl, tv[t].ef);
            chk_i($sformatf("vec%0d_fault_src", t), osrc, tv[t].es);
            chk_i($sformatf("vec%0d_timeout", t), oto, tv[t].et);
        end

        // fault_clr clears every sticky flag on the next edge.
        fault_clr = 1'b1;
        @(posedge HCLK); #1;
        fault_clr = 1'b0;
        chk_i("clr_fault", fault, 0);
        chk_i("clr_fault_src", fault_src, 0);
        chk_i("clr_timeout", timeout, 0);
        flt_m = 1'b0; src_m = 1'b0; to_m = 1'b0;

        // Reset during a stalled data phase abandons the transfer.
        req0_valid = 1'b1; req1_valid = 1'b0; req0_addr = 32'h5000_0050; req0_data = 32'hA5A5_0001;
        HREADYOUT = 1'b1; DLS_ERROR = 1'b0;
        @(posedge HCLK); #1;
        req0_valid = 1'b0; HREADYOUT = 1'b0;
        @(posedge HCLK); #1;
        chk_i("rst_pre_busy", busy, 1);
        chk_v("rst_pre_hwdata", 0, {44'h0, HWDATA}, {44'h0, 32'hA5A5_0001});
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        chk_v("rst_mid_data", 0, obs(), pk(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        HRESETn = 1'b1; HREADYOUT = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge HCLK); #1;
            chk_i($sformatf("rst_no_done%0d", c), {done, busy}, 0);
        end
        lg_m = 1'b1; flt_m = 1'b0; src_m = 1'b0; to_m = 1'b0;
        build(1'b1, 1'b1, 32'h5000_0060, 32'h0000_0061, 32'h5000_0064, 32'h0000_0062, 0, 4'h0, 4'h0);
        play(og, odn, ofl, osrc, oto);
        chk_i("post_rst_grant", og, 0);

        // Random transfers with random stalls, lockstep errors, clears and ignored inputs.
        rnd_clr = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int vs, st;
            vs = $urandom_range(1, 3);
            st = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 4);
            build(vs[0], vs[1], $urandom, $urandom, $urandom, $urandom, st,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            play(og, odn, ofl, osrc, oto);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
